status_ctx_reg: RTL and testbench

STATUS_CTX_REG -- requirements
Module: status_ctx_reg

---
 rtl/status_ctx_pkg.sv | 28 ++
 rtl/ctx_stack.sv | 44 ++++
 rtl/status_ctx_reg.sv | 104 ++++++++++
 tb/tb_status_ctx_reg.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/status_ctx_pkg.sv
// Shared defaults, flag bit positions and stack-operation decode for status_ctx_reg.
package status_ctx_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    localparam int unsigned ZERO  = 0;
    localparam int unsigned DC    = 1;
    localparam int unsigned CARRY = 2;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_BAD_PUSH,
        OP_BAD_POP
    } stack_op_e;

    // Simultaneous push and pop cancel out and never count as an error.
    function automatic stack_op_e decode_op(input logic push, input logic pop,
                                            input logic full, input logic empty);
        if (push && pop) return OP_NONE;
        if (push)        return full  ? OP_BAD_PUSH : OP_PUSH;
        if (pop)         return empty ? OP_BAD_POP  : OP_POP;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/ctx_stack.sv
// LIFO context store: WIDTH-bit entries, DEPTH deep, occupancy pointer drives full/empty.
module ctx_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_en,
    input  logic             pop_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    top_idx;

    always_comb begin
        ptr_d = ptr_q;
        if (push_en)     ptr_d = ptr_q + 1'b1;
        else if (pop_en) ptr_d = ptr_q - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    // Contents are not reset; the pointer alone defines what is valid.
    always_ff @(posedge clock) begin
        if (reset && push_en) mem_q[ptr_q[AW-1:0]] <= wr_data;
    end

    assign top_idx = ptr_q[AW-1:0] - 1'b1;
    assign top     = mem_q[top_idx];
    assign full    = (ptr_q == PW'(DEPTH));
    assign empty   = (ptr_q == '0);

endmodule

// File: rtl/status_ctx_reg.sv
// Status register with context save/restore stack; sticky ovf/unf errors are
// enabled by defining STATUS_CTX_REG_ERRFLAG_EN.
module status_ctx_reg
    import status_ctx_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned CARRY_BIT = CARRY,
    parameter int unsigned ZERO_BIT  = ZERO
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             out_en,
    input  logic             write_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0] flag_wr,
    input  logic [WIDTH-1:0] flag_in,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] status,
    output logic             carry_out,
    output logic             zero_out,
    output logic             full,
    output logic             empty,
    input  logic             err_clr,
    output logic             ovf,
    output logic             unf
);

    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] stack_top;
    stack_op_e        op;

    assign op = decode_op(push, pop, full, empty);

    ctx_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clock   (clock),
        .reset   (reset),
        .push_en (op == OP_PUSH),
        .pop_en  (op == OP_POP),
        .wr_data (status_q),
        .top     (stack_top),
        .full    (full),
        .empty   (empty)
    );

    // Applied lowest priority first so later assignments win.
    always_comb begin
        status_d = status_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (flag_wr[i]) status_d[i] = flag_in[i];
        end
        if (write_en)     status_d = data_in;
        if (op == OP_POP) status_d = stack_top;
    end

    always_ff @(posedge clock) begin
        if (!reset) status_q <= '0;
        else        status_q <= status_d;
    end

    assign status    = status_q;
    assign carry_out = status_q[CARRY_BIT];
    assign zero_out  = status_q[ZERO_BIT];
    assign data_out  = out_en ? status_q : 'z;

`ifdef STATUS_CTX_REG_ERRFLAG_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (op == OP_BAD_PUSH) ovf_d = 1'b1;
        if (op == OP_BAD_POP)  unf_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_status_ctx_reg.sv
// Directed vector bench for status_ctx_reg (default parameters).
module tb_status_ctx_reg;

`ifdef STATUS_CTX_REG_ERRFLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clock, reset, out_en, write_en, push, pop, err_clr;
    logic [7:0] data_in, flag_wr, flag_in;
    logic [7:0] data_out, status;
    logic       carry_out, zero_out, full, empty, ovf, unf;

    int checks = 0;
    int errors = 0;

    status_ctx_reg #(
        .WIDTH     (8),
        .DEPTH     (4),
        .CARRY_BIT (2),
        .ZERO_BIT  (0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .out_en    (out_en),
        .write_en  (write_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .flag_wr   (flag_wr),
        .flag_in   (flag_in),
        .push      (push),
        .pop       (pop),
        .status    (status),
        .carry_out (carry_out),
        .zero_out  (zero_out),
        .full      (full),
        .empty     (empty),
        .err_clr   (err_clr),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       we;
        logic [7:0] din;
        logic [7:0] fwr;
        logic [7:0] fin;
        logic       psh;
        logic       pp;
        logic       clr;
        logic       oe;
        logic [7:0] st;
        logic       fl;
        logic       em;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] st, input logic fl,
                           input logic em, input logic ov, input logic un);
        chk({tag, ".status"}, status, st);
        chk({tag, ".carry"}, {7'd0, carry_out}, {7'd0, st[2]});
        chk({tag, ".zero"}, {7'd0, zero_out}, {7'd0, st[0]});
        chk({tag, ".full"}, {7'd0, full}, {7'd0, fl});
        chk({tag, ".empty"}, {7'd0, empty}, {7'd0, em});
        chk({tag, ".ovf"}, {7'd0, ovf}, {7'd0, ov & ERR_EN});
        chk({tag, ".unf"}, {7'd0, unf}, {7'd0, un & ERR_EN});
        if (out_en) chk({tag, ".data_out"}, data_out, st);
    endtask

    task automatic idle();
        write_en = 0; data_in = 0; flag_wr = 0; flag_in = 0;
        push = 0; pop = 0; err_clr = 0; out_en = 0;
    endtask

    task automatic add(input logic we, input logic [7:0] din, input logic [7:0] fwr,
                       input logic [7:0] fin, input logic psh, input logic pp,
                       input logic clr, input logic oe, input logic [7:0] st,
                       input logic fl, input logic em, input logic ov, input logic un);
        vec_t v;
        v = '{we, din, fwr, fin, psh, pp, clr, oe, st, fl, em, ov, un};
        vecs.push_back(v);
    endtask

    initial begin
        //   we din    fwr    fin    psh pp clr oe  status fl em ov un
        add(1, 8'hA5, 8'h00, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 1, 0, 0);
        add(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'hA5, 0, 1, 0, 0);
        add(1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 8'h05, 8'h04, 0, 0, 0, 1, 8'h04, 0, 1, 0, 0);
        add(1, 8'hF0, 8'h05, 8'h04, 0, 0, 0, 1, 8'hF0, 0, 1, 0, 0);
        add(1, 8'h11, 8'h00, 8'h00, 0, 0, 0, 0, 8'h11, 0, 1, 0, 0);
        add(1, 8'h22, 8'h00, 8'h00, 1, 0, 0, 0, 8'h22, 0, 0, 0, 0);
        add(1, 8'h33, 8'h00, 8'h00, 1, 0, 0, 0, 8'h33, 0, 0, 0, 0);
        add(1, 8'h44, 8'h00, 8'h00, 1, 0, 0, 0, 8'h44, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 8'h44, 1, 0, 0, 0);
        add(0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 8'h44, 1, 0, 1, 0);
        add(0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1, 8'h44, 0, 0, 1, 0);
        add(0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1, 8'h33, 0, 0, 1, 0);
        add(0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1, 8'h22, 0, 0, 1, 0);
        add(0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1, 8'h11, 0, 1, 1, 0);
        add(1, 8'h3C, 8'h00, 8'h00, 0, 0, 0, 0, 8'h3C, 0, 1, 1, 0);
        add(0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 8'h3C, 0, 1, 1, 1);
        add(0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 8'h3C, 0, 1, 0, 0);
        add(0, 8'h00, 8'h00, 8'h00, 0, 1, 1, 0, 8'h3C, 0, 1, 0, 1);
        add(0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 8'h3C, 0, 1, 0, 0);
        add(1, 8'h55, 8'h00, 8'h00, 0, 0, 0, 0, 8'h55, 0, 1, 0, 0);
        add(1, 8'h66, 8'h00, 8'h00, 1, 0, 0, 0, 8'h66, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 8'h66, 0, 0, 0, 0);
        add(0, 8'h00, 8'h01, 8'h01, 1, 0, 0, 0, 8'h67, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1, 8'h66, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1, 8'h55, 0, 1, 0, 0);
        add(1, 8'hAA, 8'h00, 8'h00, 1, 0, 0, 0, 8'hAA, 0, 0, 0, 0);
        add(1, 8'h0F, 8'hFF, 8'h00, 0, 1, 0, 1, 8'h55, 0, 1, 0, 0);
        add(1, 8'hC3, 8'h00, 8'h00, 1, 1, 0, 1, 8'hC3, 0, 1, 0, 0);

        idle();
        reset = 0;
        write_en = 1; data_in = 8'hFF; push = 1;
        repeat (2) @(posedge clock);
        #1;
        idle();
        chk_all("reset", 8'h00, 0, 1, 0, 0);
        out_en = 1;
        #1 chk("reset.data_out_oe", data_out, 8'h00);

        @(negedge clock);
        reset = 1;
        for (int i = 0; i < vecs.size(); i++) begin
            write_en = vecs[i].we;  data_in = vecs[i].din;
            flag_wr  = vecs[i].fwr; flag_in = vecs[i].fin;
            push     = vecs[i].psh; pop     = vecs[i].pp;
            err_clr  = vecs[i].clr; out_en  = vecs[i].oe;
            @(posedge clock);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].fl, vecs[i].em,
                    vecs[i].ov, vecs[i].un);
            @(negedge clock);
        end

        // Reset arriving mid-push with three entries stacked and an error pending.
        idle(); pop = 1;
        @(posedge clock); #1;
        chk_all("rst_seq.unf", 8'hC3, 0, 1, 0, 1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            idle(); push = 1; write_en = 1; data_in = 8'(i);
            @(posedge clock); #1;
        end
        chk_all("rst_seq.three", 8'h03, 0, 0, 0, 1);
        @(negedge clock);
        idle(); push = 1; write_en = 1; data_in = 8'h5A; reset = 0; out_en = 1;
        @(posedge clock); #1;
        chk_all("rst_seq.cleared", 8'h00, 0, 1, 0, 0);

        // Stack usable again after reset: push then pop restores the saved value.
        @(negedge clock);
        idle(); reset = 1; push = 1; write_en = 1; data_in = 8'h81;
        @(posedge clock); #1;
        chk_all("post_rst.push", 8'h81, 0, 0, 0, 0);
        @(negedge clock);
        idle(); pop = 1; out_en = 1;
        @(posedge clock); #1;
        chk_all("post_rst.pop", 8'h00, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
